l2_spi_arbiter: RTL and testbench

L2_SPI_ARBITER -- requirements
Module: l2_spi_arbiter

---
 rtl/l2_spi_arbiter_pkg.sv | 7 +
 rtl/l2_rr_arb2.sv | 10 +
 rtl/l2_spi_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l2_spi_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_spi_arbiter_pkg.sv
// l2_spi_arbiter_pkg: shared FSM encoding and sizing for the two-requester SPI arbiter
package l2_spi_arbiter_pkg;
    localparam int N_REQ = 2;
    localparam int CNT_W = 8;
    localparam int LEN_W = 5;
    typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, XFER, CS_HOLD} state_t;
endpackage

// File: rtl/l2_rr_arb2.sv
// l2_rr_arb2: two-way round-robin pick; ptr is the index served last
module l2_rr_arb2
    import l2_spi_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             ptr,
    output logic [N_REQ-1:0] gnt
);
    always_comb gnt = (&req) ? (ptr ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/l2_spi_arbiter.sv
// l2_spi_arbiter: grants one SPI master to two requesters with CS guard timing,
// per-byte handshake with the master and a per-byte timeout.
module l2_spi_arbiter
    import l2_spi_arbiter_pkg::*;
#(
    parameter int CS_GUARD = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [7:0]       i_len,
    input  logic [15:0]      i_tx_data,
    output logic [N_REQ-1:0] o_tx_ack,
    output logic [7:0]       o_rx_data,
    output logic [N_REQ-1:0] o_rx_valid,
    output logic [N_REQ-1:0] o_grant,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_err,
    output logic [N_REQ-1:0] o_cs_n,
    output logic             om_work_en,
    output logic [7:0]       om_data,
    input  logic [7:0]       im_data,
    input  logic             im_send_finish,
    input  logic             im_receive_finish
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             idx_q, idx_d, ptr_q, ptr_d;
    logic             snd_q, snd_d, rcv_q, rcv_d, err_flag_q, err_flag_d;
    logic [N_REQ-1:0] grant_q, grant_d, cs_n_q, cs_n_d;
    logic [N_REQ-1:0] tx_ack_q, tx_ack_d, rx_valid_q, rx_valid_d;
    logic [N_REQ-1:0] done_q, done_d, err_q, err_d;
    logic             work_en_q, work_en_d;
    logic [7:0]       data_q, data_d, rx_data_q, rx_data_d;
    logic [N_REQ-1:0] gnt;
    logic [3:0]       len_sel;

    l2_rr_arb2 u_arb (.req(i_req), .ptr(ptr_q), .gnt(gnt));

    // A nibble of zero encodes 16 bytes, which is exactly the carry bit.
    assign len_sel = gnt[1] ? i_len[7:4] : i_len[3:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        snd_d      = snd_q;
        rcv_d      = rcv_q;
        err_flag_d = err_flag_q;
        grant_d    = grant_q;
        cs_n_d     = cs_n_q;
        work_en_d  = work_en_q;
        data_d     = data_q;
        rx_data_d  = rx_data_q;
        tx_ack_d   = '0;
        rx_valid_d = '0;
        done_d     = '0;
        err_d      = '0;
        case (state_q)
            IDLE: if (|i_req) begin
                idx_d   = gnt[1];
                grant_d = gnt;
                cs_n_d  = ~gnt;
                rem_d   = {len_sel == 4'd0, len_sel};
                cnt_d   = '0;
                state_d = CS_SETUP;
            end
            CS_SETUP: begin
                cnt_d   = (cnt_q == CNT_W'(CS_GUARD - 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(CS_GUARD - 1)) ? LOAD : CS_SETUP;
            end
            LOAD: begin
                data_d    = idx_q ? i_tx_data[15:8] : i_tx_data[7:0];
                tx_ack_d  = grant_q;
                work_en_d = 1'b1;
                snd_d     = 1'b0;
                rcv_d     = 1'b0;
                cnt_d     = '0;
                state_d   = XFER;
            end
            XFER: begin
                snd_d = snd_q | im_send_finish;
                rcv_d = rcv_q | im_receive_finish;
                cnt_d = cnt_q + 1'b1;
                if (snd_d && rcv_d) begin
                    work_en_d  = 1'b0;
                    rx_data_d  = im_data;
                    rx_valid_d = grant_q;
                    rem_d      = rem_q - 1'b1;
                    cnt_d      = '0;
                    state_d    = (rem_q == LEN_W'(1)) ? CS_HOLD : LOAD;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    work_en_d  = 1'b0;
                    err_flag_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = CS_HOLD;
                end
            end
            CS_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(CS_GUARD - 1)) begin
                    cs_n_d     = '1;
                    grant_d    = '0;
                    done_d     = grant_q;
                    err_d      = err_flag_q ? grant_q : '0;
                    err_flag_d = 1'b0;
                    ptr_d      = idx_q;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            idx_q      <= 1'b0;
            ptr_q      <= 1'b1;
            snd_q      <= 1'b0;
            rcv_q      <= 1'b0;
            err_flag_q <= 1'b0;
            grant_q    <= '0;
            cs_n_q     <= '1;
            work_en_q  <= 1'b0;
            data_q     <= '0;
            rx_data_q  <= '0;
            tx_ack_q   <= '0;
            rx_valid_q <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            snd_q      <= snd_d;
            rcv_q      <= rcv_d;
            err_flag_q <= err_flag_d;
            grant_q    <= grant_d;
            cs_n_q     <= cs_n_d;
            work_en_q  <= work_en_d;
            data_q     <= data_d;
            rx_data_q  <= rx_data_d;
            tx_ack_q   <= tx_ack_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_tx_ack   = tx_ack_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_grant    = grant_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_cs_n     = cs_n_q;
    assign om_work_en = work_en_q;
    assign om_data    = data_q;
endmodule

// File: tb/tb_l2_spi_arbiter.sv
// tb_l2_spi_arbiter: vector table, reset-abort sequence and randomized transactions
// checked against a transaction-level timing model of the arbiter.
module tb_l2_spi_arbiter;
    localparam int GUARD = 2;
    localparam int TO    = 10;

    logic       clk, rst;
    logic [1:0] i_req, o_tx_ack, o_rx_valid, o_grant, o_done, o_err, o_cs_n;
    logic [7:0] i_len, o_rx_data, om_data, im_data;
    logic [15:0] i_tx_data;
    logic       om_work_en, im_send_finish, im_receive_finish;

    l2_spi_arbiter #(.CS_GUARD(GUARD), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_len(i_len), .i_tx_data(i_tx_data),
        .o_tx_ack(o_tx_ack), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_grant(o_grant), .o_done(o_done), .o_err(o_err), .o_cs_n(o_cs_n),
        .om_work_en(om_work_en), .om_data(om_data), .im_data(im_data),
        .im_send_finish(im_send_finish), .im_receive_finish(im_receive_finish)
    );

    typedef struct {
        int lat; int grant; int gcyc; int acks; int rx; int wen; int done; int err; int viol;
    } obs_t;

    typedef struct {
        logic [1:0] req; logic [7:0] len; logic [15:0] tx;
        int s; int r; bit sp; bit mut; bit hold; int miso;
        int win; int gcyc; int acks; int rx; int wen; bit err;
    } vec_t;

    int n_chk = 0, n_fail = 0, inv_bad = 0;
    int snd_dly = 0, rcv_dly = 0, miso_val = -1;
    bit spur = 0;
    logic [7:0] miso_q[$];
    obs_t obs;
    vec_t tbl[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    // Slave model: finish pulses at configured cycles of each byte, random noise outside bytes.
    initial begin
        int k;
        k = 0;
        im_send_finish = 1'b0;
        im_receive_finish = 1'b0;
        im_data = 8'h00;
        forever begin
            @(negedge clk);
            k = om_work_en ? k + 1 : 0;
            if (k == 1) begin
                im_data = (miso_val >= 0) ? 8'(miso_val) : 8'($urandom);
                miso_q.push_back(im_data);
            end
            im_send_finish    = (k != 0) ? (k == snd_dly) : (spur && $urandom_range(0, 1) == 1);
            im_receive_finish = (k != 0) ? (k == rcv_dly) : (spur && $urandom_range(0, 1) == 1);
        end
    end

    always @(negedge clk)
        if (!rst && (o_cs_n != ~o_grant || !$onehot0(o_grant))) inv_bad++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run(input logic [1:0] req, input logic [7:0] len, input logic [15:0] tx,
                       input int s, input int r, input bit sp, input bit mut, input int miso);
        logic [1:0] g;
        int cyc;
        i_req = req; i_len = len; i_tx_data = tx;
        snd_dly = s; rcv_dly = r; spur = sp; miso_val = miso;
        miso_q.delete();
        obs = '{default: 0};
        @(negedge clk);
        obs.lat = 1;
        while (o_grant == 2'b00 && obs.lat < 4) begin
            @(negedge clk);
            obs.lat++;
        end
        g = o_grant;
        obs.grant = g;
        cyc = 0;
        while (o_grant != 2'b00 && cyc < 2000) begin
            obs.gcyc++;
            if (o_grant != g || o_cs_n != ~g || o_done != 2'b00 || o_err != 2'b00) obs.viol++;
            if (o_tx_ack != 2'b00) begin
                obs.acks++;
                if (o_tx_ack != g || om_data != (g[1] ? tx[15:8] : tx[7:0])) obs.viol++;
            end
            if (o_rx_valid != 2'b00) begin
                obs.rx++;
                if (o_rx_valid != g || miso_q.size() == 0) obs.viol++;
                else if (o_rx_data != miso_q.pop_front()) obs.viol++;
            end
            obs.wen += int'(om_work_en);
            if (mut && obs.gcyc == 3) begin
                i_req = ~req;
                i_len = ~len;
            end
            cyc++;
            @(negedge clk);
        end
        obs.done = o_done;
        obs.err = o_err;
        if (o_cs_n != 2'b11 || om_work_en) obs.viol++;
    endtask

    task automatic expect_obs(input string nm, input int win, input int gcyc, input int acks,
                              input int rx, input int wen, input bit err);
        int oh;
        oh = 1 << win;
        chk({nm, ".grant_latency"}, obs.lat, 1);
        chk({nm, ".grant"}, obs.grant, oh);
        chk({nm, ".grant_cycles"}, obs.gcyc, gcyc);
        chk({nm, ".tx_acks"}, obs.acks, acks);
        chk({nm, ".rx_valids"}, obs.rx, rx);
        chk({nm, ".work_en_cycles"}, obs.wen, wen);
        chk({nm, ".done"}, obs.done, oh);
        chk({nm, ".err"}, obs.err, err ? oh : 0);
        chk({nm, ".protocol"}, obs.viol, 0);
    endtask

    initial begin
        int m_ptr, acks, cyc, bad;
        rst = 1'b1; i_req = 2'b00; i_len = 8'h00; i_tx_data = 16'h0000;
        // req, len, tx, s, r, spur, mutate, hold, miso | win, grant cycles, acks, rx, work_en cycles, err
        tbl[0]  = '{2'b11, 8'h11, 16'h3C5A, 1,  1,  0, 0, 1, -1,  0, 6,  1,  1,  1,  0};
        tbl[1]  = '{2'b11, 8'h11, 16'h7E81, 1,  1,  0, 0, 1, -1,  1, 6,  1,  1,  1,  0};
        tbl[2]  = '{2'b11, 8'h11, 16'h1299, 1,  1,  0, 0, 0, -1,  0, 6,  1,  1,  1,  0};
        tbl[3]  = '{2'b01, 8'h01, 16'h0064, 2,  2,  0, 0, 0, 255, 0, 7,  1,  1,  2,  0};
        tbl[4]  = '{2'b10, 8'h00, 16'hA500, 1,  3,  0, 0, 0, -1,  1, 68, 16, 16, 48, 0};
        tbl[5]  = '{2'b01, 8'h01, 16'h00C3, 3,  7,  0, 0, 0, -1,  0, 12, 1,  1,  7,  0};
        tbl[6]  = '{2'b01, 8'h02, 16'h0042, 5,  5,  0, 0, 0, -1,  0, 16, 2,  2,  10, 0};
        tbl[7]  = '{2'b01, 8'h03, 16'h0011, 0,  0,  0, 0, 0, -1,  0, 15, 1,  0,  10, 1};
        tbl[8]  = '{2'b01, 8'h01, 16'h00EE, 10, 10, 0, 0, 0, -1,  0, 15, 1,  1,  10, 0};
        tbl[9]  = '{2'b11, 8'h11, 16'h5566, 11, 2,  0, 0, 0, -1,  1, 15, 1,  0,  10, 1};
        tbl[10] = '{2'b10, 8'h30, 16'h9900, 2,  1,  1, 1, 0, -1,  1, 13, 3,  3,  6,  0};
        tbl[11] = '{2'b11, 8'h21, 16'h4433, 4,  4,  1, 0, 0, -1,  0, 9,  1,  1,  4,  0};

        repeat (3) @(negedge clk);
        chk("reset.cs_n", o_cs_n, 3);
        chk("reset.grant", o_grant, 0);
        chk("reset.work_en", om_work_en, 0);
        chk("reset.om_data", om_data, 0);
        chk("reset.rx_data", o_rx_data, 0);
        chk("reset.pulses", {o_tx_ack, o_rx_valid, o_done, o_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run(tbl[i].req, tbl[i].len, tbl[i].tx, tbl[i].s, tbl[i].r, tbl[i].sp, tbl[i].mut, tbl[i].miso);
            expect_obs($sformatf("vec%0d", i), tbl[i].win, tbl[i].gcyc, tbl[i].acks,
                       tbl[i].rx, tbl[i].wen, tbl[i].err);
            if (!tbl[i].hold) begin
                i_req = 2'b00;
                repeat (2) @(negedge clk);
            end
        end

        // Abort in the middle of byte 2 of 4; last completed owner was req0.
        i_req = 2'b01; i_len = 8'h04; i_tx_data = 16'h00AB;
        snd_dly = 3; rcv_dly = 3; spur = 1'b0; miso_val = -1;
        acks = 0; cyc = 0;
        while (acks < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_tx_ack != 2'b00) acks++;
        end
        chk("abort.reach_byte2", acks, 2);
        @(negedge clk);
        rst = 1'b1; i_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.cs_n", o_cs_n, 3);
        chk("abort.work_en", om_work_en, 0);
        chk("abort.grant", o_grant, 0);
        chk("abort.done_err", {o_done, o_err}, 0);
        chk("abort.om_data", om_data, 0);
        chk("abort.rx_data", o_rx_data, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done != 2'b00 || o_err != 2'b00 || o_grant != 2'b00) bad++;
        end
        chk("abort.no_release", bad, 0);
        run(2'b11, 8'h11, 16'h2211, 1, 1, 0, 0, -1);
        expect_obs("post_reset_tie", 0, 6, 1, 1, 1, 0);
        i_req = 2'b00;
        @(negedge clk);
        m_ptr = 0;

        for (int i = 0; i < 40; i++) begin
            logic [1:0] req;
            logic [7:0] len;
            int s, r, win, nb, mx, x, att;
            bit to, sp, mut;
            req = 2'($urandom_range(1, 3));
            len = 8'($urandom);
            s = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            r = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            sp = 1'($urandom_range(0, 1));
            mut = ($urandom_range(0, 3) == 0);
            win = (req == 2'b11) ? ((m_ptr == 1) ? 0 : 1) : ((req == 2'b10) ? 1 : 0);
            nb = win ? int'(len[7:4]) : int'(len[3:0]);
            if (nb == 0) nb = 16;
            mx = (s > r) ? s : r;
            to = (s == 0 || r == 0 || mx > TO);
            x = to ? TO : mx;
            att = to ? 1 : nb;
            run(req, len, 16'($urandom), s, r, sp, mut, -1);
            expect_obs($sformatf("rand%0d", i), win, 2 * GUARD + att * (1 + x), att,
                       to ? 0 : nb, att * x, to);
            m_ptr = win;
            if ($urandom_range(0, 1) == 0) begin
                i_req = 2'b00;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        i_req = 2'b00;
        repeat (3) @(negedge clk);
        chk("cs_grant_invariant", inv_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
